// File: rtl/lane_capture_pkg.sv
// Shared types and constants for the lane_capture_8 slice.
// Optional byte parity output is enabled with LANE_CAPTURE_PARITY_EN.
package lane_capture_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  localparam logic [LANES-1:0] LANE_ONE  = {{(LANES-1){1'b0}}, 1'b1};
  localparam logic [LANES-1:0] LANE_ALL  = {LANES{1'b1}};
  localparam logic [LANES-1:0] LANE_NONE = {LANES{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } cap_state_e;

  function automatic logic byte_parity_f(input logic [LANES-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lane_capture_if.sv
// Capture/handshake bundle between the demux sampler, lane_capture_8 and its consumer.
// byte_parity exists only when LANE_CAPTURE_PARITY_EN is defined.
interface lane_capture_if;
  import lane_capture_pkg::*;

  logic [LANES-1:0] d;
  logic [SEL_W-1:0] sel;
  logic             strobe;
  logic [LANES-1:0] byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic [LANES-1:0] lane_mask;
  logic             seq_err;
  logic             overrun;
`ifdef LANE_CAPTURE_PARITY_EN
  logic             byte_parity;

  modport master (output d, sel, strobe, byte_ready,
                  input  byte_out, byte_valid, lane_mask, seq_err, overrun, byte_parity);
  modport slave  (input  d, sel, strobe, byte_ready,
                  output byte_out, byte_valid, lane_mask, seq_err, overrun, byte_parity);
`else
  modport master (output d, sel, strobe, byte_ready,
                  input  byte_out, byte_valid, lane_mask, seq_err, overrun);
  modport slave  (input  d, sel, strobe, byte_ready,
                  output byte_out, byte_valid, lane_mask, seq_err, overrun);
`endif

endinterface

// File: rtl/lane_shadow_reg.sv
// Per-lane shadow bits and capture mask; clear and a single-lane write may share a cycle
// (the write wins for its lane, so a fresh byte can start on the clearing edge).
module lane_shadow_reg
  import lane_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [SEL_W-1:0] sel,
  input  logic             bit_in,
  output logic [LANES-1:0] shadow,
  output logic [LANES-1:0] mask
);

  logic [LANES-1:0] shadow_r;
  logic [LANES-1:0] mask_r;
  logic [LANES-1:0] lane_bit_s;
  logic [LANES-1:0] shadow_nxt_s;
  logic [LANES-1:0] mask_nxt_s;

  // Next shadow/mask from the one-hot write enable of the selected lane
  always_comb begin
    lane_bit_s   = we ? (LANE_ONE << sel) : LANE_NONE;
    shadow_nxt_s = (shadow_r & ~lane_bit_s) | ({LANES{bit_in}} & lane_bit_s);
    mask_nxt_s   = (clr ? LANE_NONE : mask_r) | lane_bit_s;
  end

  // Shadow and mask state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= LANE_NONE;
      mask_r   <= LANE_NONE;
    end else begin
      shadow_r <= shadow_nxt_s;
      mask_r   <= mask_nxt_s;
    end
  end

  assign shadow = shadow_r;
  assign mask   = mask_r;

endmodule

// File: rtl/lane_capture_8.sv
// Assembles one byte from eight demux lanes sampled one per strobe, then holds it for a
// valid/ready consumer. Optional byte_parity output: define LANE_CAPTURE_PARITY_EN.
module lane_capture_8
  import lane_capture_pkg::*;
#(
  parameter int STRICT_ORDER = 1
) (
  input logic         clk,
  input logic         rst,
  lane_capture_if.slave bus
);

  localparam logic STRICT_S = (STRICT_ORDER != 32'sd0);

  cap_state_e       state_r;
  cap_state_e       state_nxt_s;
  logic [SEL_W-1:0] expect_r;
  logic [SEL_W-1:0] expect_nxt_s;
  logic [LANES-1:0] byte_r;
  logic [LANES-1:0] byte_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic             seq_err_r;
  logic             seq_err_nxt_s;
  logic             overrun_r;
  logic             overrun_nxt_s;
  logic             clr_s;
  logic             we_s;
  logic [LANES-1:0] shadow_s;
  logic [LANES-1:0] mask_s;
  logic [LANES-1:0] lane_bit_s;

  assign lane_bit_s = LANE_ONE << bus.sel;

  lane_shadow_reg u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .we     (we_s),
    .sel    (bus.sel),
    .bit_in (bus.d[bus.sel]),
    .shadow (shadow_s),
    .mask   (mask_s)
  );

  // Next-state, capture control and error pulses
  always_comb begin
    state_nxt_s   = state_r;
    expect_nxt_s  = expect_r;
    byte_nxt_s    = byte_r;
    valid_nxt_s   = valid_r;
    seq_err_nxt_s = 1'b0;
    overrun_nxt_s = 1'b0;
    clr_s         = 1'b0;
    we_s          = 1'b0;
    case (state_r)
      FILL: begin
        if (bus.strobe) begin
          if (STRICT_S && (bus.sel != expect_r)) begin
            seq_err_nxt_s = 1'b1;
            clr_s         = 1'b1;
            expect_nxt_s  = SEL_ZERO;
          end else begin
            we_s         = 1'b1;
            expect_nxt_s = bus.sel + SEL_ONE;
            // The completing lane is merged straight from d so byte_out lands one edge later
            if ((mask_s | lane_bit_s) == LANE_ALL) begin
              byte_nxt_s  = (shadow_s & ~lane_bit_s) | (bus.d & lane_bit_s);
              valid_nxt_s = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = FILL;
            end
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      HOLD: begin
        if (bus.byte_ready) begin
          valid_nxt_s  = 1'b0;
          clr_s        = 1'b1;
          expect_nxt_s = SEL_ZERO;
          state_nxt_s  = FILL;
          if (bus.strobe) begin
            if (STRICT_S && (bus.sel != SEL_ZERO)) begin
              seq_err_nxt_s = 1'b1;
            end else begin
              we_s         = 1'b1;
              expect_nxt_s = bus.sel + SEL_ONE;
            end
          end else begin
            we_s = 1'b0;
          end
        end else if (bus.strobe) begin
          overrun_nxt_s = 1'b1;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s  = FILL;
        valid_nxt_s  = 1'b0;
        clr_s        = 1'b1;
        expect_nxt_s = SEL_ZERO;
      end
    endcase
  end

  // FSM, held byte and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FILL;
      expect_r  <= SEL_ZERO;
      byte_r    <= LANE_NONE;
      valid_r   <= 1'b0;
      seq_err_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      expect_r  <= expect_nxt_s;
      byte_r    <= byte_nxt_s;
      valid_r   <= valid_nxt_s;
      seq_err_r <= seq_err_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  assign bus.byte_out   = byte_r;
  assign bus.byte_valid = valid_r;
  assign bus.lane_mask  = mask_s;
  assign bus.seq_err    = seq_err_r;
  assign bus.overrun    = overrun_r;

`ifdef LANE_CAPTURE_PARITY_EN
  logic parity_r;

  // Parity tracks byte_out on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= byte_parity_f(byte_nxt_s);
    end
  end

  assign bus.byte_parity = parity_r;
`endif

endmodule
